sram_rw0_requester: RTL and testbench

Requester-side controller for the single-port 256x22 masked SRAM macros used in the XiangShan arrays (RW0 interface: addr/en/wmode/wmask/wdata in, rdata out one cycle later). Accepts read/write requests on a valid/ready channel, drives the SRAM RW0 port, and captures read data into a 2-entry response buffer. The buffer is needed because the macro's rdata is only guaranteed during the cycle after the read. Optionally zero-fills the whole array after reset. Sits between a cache/predictor pipeline stage and one `*_ext` array instance.

---
 rtl/sram_rw0_requester_pkg.sv | 21 ++
 rtl/sram_resp_fifo2.sv | 68 ++++++
 rtl/sram_rw0_requester.sv | 162 ++++++++++++++++
 tb/tb_sram_rw0_requester.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_rw0_requester_pkg.sv
// ---------------------------------------------------------------------------
// sram_rw0_requester_pkg
//
// Purpose: shared defaults and types for the RW0 requester slice.
//   DEF_ADDR_W / DEF_DATA_W / DEF_DEPTH : geometry of the 256x22 masked
//                                         single-port macro.
//   state_e                             : controller state (INIT sweep, RUN).
// Configuration macro used by the slice: SRAM_RW0_INIT_EN.
// ---------------------------------------------------------------------------
package sram_rw0_requester_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 22;
    localparam int DEF_DEPTH  = 256;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sram_resp_fifo2.sv
// ---------------------------------------------------------------------------
// sram_resp_fifo2
//
// Purpose: two-entry response buffer. Captures the macro's read data during
// the only cycle it is guaranteed and holds it until the consumer takes it.
//
// Ports:
//   clock       in   sole clock
//   reset       in   synchronous, active-high; empties the buffer
//   push_i      in   write pushData_i into the tail
//   pushData_i  in   DATA_W data to store
//   pop_i       in   drop the head entry (only while valid_o)
//   popData_o   out  head entry (zero after reset)
//   valid_o     out  buffer holds at least one entry
//   occ_o       out  occupancy, 0..2
// ---------------------------------------------------------------------------
module sram_resp_fifo2
    import sram_rw0_requester_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] pushData_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] popData_o,
    output logic              valid_o,
    output logic [1:0]        occ_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wrPtr_q;
    logic              rdPtr_q;
    logic [1:0]        occ_q;

    // Storage, pointers and occupancy. The caller's credit rule guarantees
    // no push while full and no pop while empty, so a simultaneous push and
    // pop simply leaves the occupancy unchanged while both pointers advance,
    // which keeps entries in arrival order.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wrPtr_q  <= 1'b0;
            rdPtr_q  <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wrPtr_q] <= pushData_i;
                wrPtr_q        <= ~wrPtr_q;
            end
            if (pop_i) begin
                rdPtr_q <= ~rdPtr_q;
            end
            case ({push_i, pop_i})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign popData_o = mem_q[rdPtr_q];
    assign valid_o   = (occ_q != 2'd0);
    assign occ_o     = occ_q;

endmodule

// File: rtl/sram_rw0_requester.sv
// ---------------------------------------------------------------------------
// sram_rw0_requester
//
// Purpose: requester-side controller for one single-port masked SRAM macro
// (RW0 interface). Accepts read/write requests on a valid/ready channel,
// drives the RW0 port combinationally from the accepted request, and buffers
// read data (available one cycle after the read) in a 2-entry FIFO.
//
// Optional feature (macro SRAM_RW0_INIT_EN): after reset, sweep the whole
// array writing zeros, one entry per cycle, before accepting requests.
//
// Ports:
//   clock, reset                 sole clock; synchronous active-high reset
//   req_valid/req_ready          request handshake
//   req_wmode/addr/wmask/wdata   request payload (wmode 1 = write)
//   resp_valid/resp_ready        read response handshake
//   resp_data                    read data, in request order
//   init_done                    array usable
//   sram_en/wmode/addr/wmask/wdata  to the macro RW0 port
//   sram_rdata                   from the macro RW0 port
// ---------------------------------------------------------------------------
module sram_rw0_requester
    import sram_rw0_requester_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wmode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wmask,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              init_done,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    if (DEPTH != (1 << ADDR_W)) begin : gDepthCheck
        $error("sram_rw0_requester: DEPTH must equal 2**ADDR_W");
    end

    state_e     state_q;
    state_e     state_d;
    logic       inflight_q;
    logic [1:0] occ;
    logic       fifoValid;
    logic       fireIn;
    logic       fireOut;
    logic [2:0] used;
    logic       creditOk;

`ifdef SRAM_RW0_INIT_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    logic [ADDR_W-1:0] sweepCnt_q;
    logic [ADDR_W-1:0] sweepCnt_d;
`endif

    assign fireIn     = req_valid && req_ready;
    assign fireOut    = fifoValid && resp_ready;
    assign resp_valid = fifoValid;

    // A request may be accepted only if the read it might issue still has a
    // buffer slot: buffered entries plus the read in flight, minus the entry
    // leaving this cycle, must stay below two.
    assign used     = {1'b0, occ} + {2'b00, inflight_q};
    assign creditOk = (used < (3'd2 + {2'b00, fireOut}));

    sram_resp_fifo2 #(
        .DATA_W (DATA_W)
    ) uRespFifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (inflight_q),
        .pushData_i (sram_rdata),
        .pop_i      (fireOut),
        .popData_o  (resp_data),
        .valid_o    (fifoValid),
        .occ_o      (occ)
    );

    // Next state and all RW0/handshake outputs. While reset is held every
    // output is forced to its idle value so nothing reaches the macro or the
    // requester. In RUN the accepted request passes straight through to the
    // macro; idle cycles hold the macro inputs at zero. INIT writes zeros to
    // the sweep counter's address each cycle and hands over to RUN after the
    // last entry.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        init_done  = 1'b0;
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = 1'b0;
        sram_wdata = '0;
`ifdef SRAM_RW0_INIT_EN
        sweepCnt_d = sweepCnt_q;
`endif
        if (!reset) begin
            case (state_q)
                RUN: begin
                    init_done = 1'b1;
                    req_ready = creditOk;
                    if (req_valid && creditOk) begin
                        sram_en    = 1'b1;
                        sram_wmode = req_wmode;
                        sram_addr  = req_addr;
                        sram_wmask = req_wmask;
                        sram_wdata = req_wdata;
                    end
                end
                default: begin
`ifdef SRAM_RW0_INIT_EN
                    sram_en    = 1'b1;
                    sram_wmode = 1'b1;
                    sram_wmask = 1'b1;
                    sram_addr  = sweepCnt_q;
                    sweepCnt_d = sweepCnt_q + 1'b1;
                    if (sweepCnt_q == LAST_ADDR) begin
                        state_d = RUN;
                    end
`else
                    state_d = RUN;
`endif
                end
            endcase
        end
    end

    // State register and the in-flight read flag. The flag marks the cycle
    // in which the macro presents read data, which is exactly when the FIFO
    // captures it; reset drops any read still in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
`ifdef SRAM_RW0_INIT_EN
            state_q    <= INIT;
            sweepCnt_q <= '0;
`else
            state_q    <= RUN;
`endif
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
`ifdef SRAM_RW0_INIT_EN
            sweepCnt_q <= sweepCnt_d;
`endif
            inflight_q <= fireIn && !req_wmode;
        end
    end

endmodule

// File: tb/tb_sram_rw0_requester.sv
// ---------------------------------------------------------------------------
// tb_sram_rw0_requester
//
// Self-checking bench for sram_rw0_requester with a behavioural model of the
// attached macro. Expected values come from a transaction-level reference:
// a shadow array updated on accepted writes, and a queue of pending read
// responses each tagged with the cycle it becomes visible. Honors the
// SRAM_RW0_INIT_EN build option.
// ---------------------------------------------------------------------------
module tb_sram_rw0_requester;

    localparam int AW  = 8;
    localparam int DW  = 22;
    localparam int DEP = 256;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_wmode;
    logic [AW-1:0] req_addr;
    logic          req_wmask;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          init_done;
    logic          sram_en;
    logic          sram_wmode;
    logic [AW-1:0] sram_addr;
    logic          sram_wmask;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    always #5 clock = ~clock;

    sram_rw0_requester #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (DEP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wmode  (req_wmode),
        .req_addr   (req_addr),
        .req_wmask  (req_wmask),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .init_done  (init_done),
        .sram_en    (sram_en),
        .sram_wmode (sram_wmode),
        .sram_addr  (sram_addr),
        .sram_wmask (sram_wmask),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // Power-up contents of the macro, reproducible from the seed.
    logic [31:0] seed;
    function automatic logic [DW-1:0] initPattern(input int i);
        return DW'((32'(i) * 32'h9E3779B1) ^ seed);
    endfunction

    // Macro model: write-then-read single port, read data valid only during
    // the cycle after the read, garbage otherwise.
    logic [DW-1:0] sramMem [DEP];
    logic          memLoaded = 1'b0;
    always @(posedge clock) begin
        if (!memLoaded) begin
            for (int i = 0; i < DEP; i++) sramMem[i] <= initPattern(i);
            memLoaded  <= 1'b1;
            sram_rdata <= DW'($urandom);
        end else if (sram_en && sram_wmode) begin
            if (sram_wmask) sramMem[sram_addr] <= sram_wdata;
            sram_rdata <= DW'($urandom);
        end else if (sram_en) begin
            sram_rdata <= sramMem[sram_addr];
        end else begin
            sram_rdata <= DW'($urandom);
        end
    end

    // Reference model state.
    typedef struct {
        int            avail;
        logic [DW-1:0] data;
    } resp_t;
    resp_t         pendQ[$];
    logic [DW-1:0] refMem [DEP];
    int            cycle;
    int            readyAt;
    int            tests;
    int            failures;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // One clock cycle: drive inputs, compare every output against the model,
    // then advance the model by the handshakes the specification implies.
    task automatic applyStimulus(input logic v, input logic wm, input logic [AW-1:0] a,
                                 input logic mk, input logic [DW-1:0] wd, input logic rr,
                                 output logic accepted);
        logic          expValid;
        logic          expReady;
        logic          expFireOut;
        logic          running;
        logic [DW-1:0] expData;
        int            outstanding;
        @(negedge clock);
        req_valid  = v;
        req_wmode  = wm;
        req_addr   = a;
        req_wmask  = mk;
        req_wdata  = wd;
        resp_ready = rr;
        #1;
        running     = (cycle >= readyAt);
        expValid    = (pendQ.size() > 0) && (pendQ[0].avail <= cycle);
        expData     = expValid ? pendQ[0].data : '0;
        expFireOut  = expValid && rr;
        outstanding = pendQ.size();
        expReady    = running && ((outstanding - int'(expFireOut)) < 2);
        accepted    = v && expReady;

        checkOutput("resp_valid", 32'(resp_valid), 32'(expValid));
        if (expValid) checkOutput("resp_data", 32'(resp_data), 32'(expData));
        checkOutput("req_ready", 32'(req_ready), 32'(expReady));
        checkOutput("init_done", 32'(init_done), 32'(running));
        if (running) begin
            checkOutput("sram_en", 32'(sram_en), 32'(accepted));
            checkOutput("sram_addr", 32'(sram_addr), accepted ? 32'(a) : 32'd0);
            checkOutput("sram_wmode", 32'(sram_wmode), accepted ? 32'(wm) : 32'd0);
            checkOutput("sram_wmask", 32'(sram_wmask), accepted ? 32'(mk) : 32'd0);
            checkOutput("sram_wdata", 32'(sram_wdata), accepted ? 32'(wd) : 32'd0);
        end else begin
            checkOutput("sweep_en", 32'(sram_en), 32'd1);
            checkOutput("sweep_addr", 32'(sram_addr), 32'(AW'(cycle)));
            checkOutput("sweep_wmode", 32'(sram_wmode), 32'd1);
            checkOutput("sweep_wmask", 32'(sram_wmask), 32'd1);
            checkOutput("sweep_wdata", 32'(sram_wdata), 32'd0);
        end

        if (expFireOut) void'(pendQ.pop_front());
        if (accepted) begin
            if (wm) begin
                if (mk) refMem[a] = wd;
            end else begin
                pendQ.push_back('{cycle + 2, refMem[a]});
            end
        end
        cycle++;
    endtask

    task automatic idleCycles(input int n, input logic rr);
        logic acc;
        repeat (n) applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, rr, acc);
    endtask

    task automatic sendReq(input logic wm, input logic [AW-1:0] a, input logic mk, input logic [DW-1:0] wd);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 40 && !acc; t++) applyStimulus(1'b1, wm, a, mk, wd, 1'b1, acc);
        checkOutput("req_accepted", 32'(acc), 32'd1);
    endtask

    // Hold reset a few cycles, check idle outputs, release it so the next
    // half-cycle is the first cycle after deassertion, and reset the model.
    task automatic doReset();
        @(negedge clock);
        reset      = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_data", 32'(resp_data), 32'd0);
        checkOutput("rst_init_done", 32'(init_done), 32'd0);
        checkOutput("rst_sram_en", 32'(sram_en), 32'd0);
        checkOutput("rst_sram_wmode", 32'(sram_wmode), 32'd0);
        checkOutput("rst_sram_addr", 32'(sram_addr), 32'd0);
        checkOutput("rst_sram_wmask", 32'(sram_wmask), 32'd0);
        checkOutput("rst_sram_wdata", 32'(sram_wdata), 32'd0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        pendQ.delete();
        cycle = 0;
`ifdef SRAM_RW0_INIT_EN
        readyAt = DEP;
        for (int i = 0; i < DEP; i++) refMem[i] = '0;
`else
        readyAt = 0;
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic acc;
        int   bpCount;
        seed       = $urandom;
        tests      = 0;
        failures   = 0;
        cycle      = 0;
        readyAt    = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_wmode  = 1'b0;
        req_addr   = '0;
        req_wmask  = 1'b0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < DEP; i++) refMem[i] = initPattern(i);

        // Reset and (optionally) the zero-fill sweep.
        doReset();
        idleCycles(readyAt + 2, 1'b1);

        // Read of a location never written: power-up or swept contents.
        sendReq(1'b0, AW'(5), 1'b0, '0);
        idleCycles(3, 1'b1);

        // Write then read the same address on the next cycle.
        sendReq(1'b1, AW'('h12), 1'b1, DW'('h2AAAAA));
        sendReq(1'b0, AW'('h12), 1'b0, '0);
        idleCycles(3, 1'b1);

        // Masked-off write must leave the old value.
        sendReq(1'b1, AW'(7), 1'b1, DW'('h000001));
        sendReq(1'b1, AW'(7), 1'b0, DW'('h3FFFFF));
        sendReq(1'b0, AW'(7), 1'b0, '0);
        idleCycles(3, 1'b1);

        // Back-to-back reads at full rate.
        for (int i = 0; i < 16; i++) sendReq(1'b1, AW'(i), 1'b1, DW'($urandom));
        for (int i = 0; i < 16; i++) sendReq(1'b0, AW'(i), 1'b0, '0);
        idleCycles(4, 1'b1);

        // Backpressure: only two reads fit while the consumer stalls.
        bpCount = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, AW'(20 + i), 1'b0, '0, 1'b0, acc);
            if (req_ready) bpCount++;
        end
        checkOutput("bp_accepted", 32'(bpCount), 32'd2);
        idleCycles(6, 1'b1);

        // Randomized traffic over a small address window for RAW hits.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                          AW'(40 + $urandom_range(0, 7)), 1'($urandom), DW'($urandom),
                          $urandom_range(0, 3) != 0, acc);
        end
        idleCycles(6, 1'b1);

        // Reset with one response buffered and one read in flight.
        applyStimulus(1'b1, 1'b0, AW'(3), 1'b0, '0, 1'b0, acc);
        applyStimulus(1'b1, 1'b0, AW'(4), 1'b0, '0, 1'b0, acc);
        doReset();
        idleCycles(readyAt + 6, 1'b1);
        sendReq(1'b0, AW'('h12), 1'b0, '0);
        sendReq(1'b0, AW'(7), 1'b0, '0);
        idleCycles(4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
